// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and constants
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_t;

    localparam logic [7:0] NOP_INSTR        = 8'h00;
    localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with push/pop/clear
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_head_valid,
    output fetch_entry_t           o_head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage carries no reset; entries are only visible through r_count.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != '0);
    assign o_head_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, imem request FSM, prefetch FIFO
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_imem_req,
    output logic [7:0] o_imem_addr,
    input  logic       i_imem_ready,
    input  logic [7:0] i_imem_rdata,
    input  logic       i_id_write_en,
    input  logic       i_redirect,
    input  logic [7:0] i_redirect_pc,
    output logic       o_if_valid,
    output logic [7:0] o_pc_out,
    output logic [7:0] o_instr_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [7:0]    r_fetch_pc;
    logic [7:0]    w_fetch_pc_next;
    logic [7:0]    r_imem_addr;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;
    logic          w_has_space;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    assign w_pop        = w_head_valid && i_id_write_en && !i_redirect;
    assign w_push       = (r_state == FS_REQ) && i_imem_ready && !i_redirect;
    assign w_push_entry = {r_imem_addr, i_imem_rdata};
    assign w_count_next = i_redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_has_space  = (w_count_next < CW'(FIFO_DEPTH));

    // Every new request is issued at the updated fetch PC, so the address
    // register simply captures w_fetch_pc_next whenever w_issue is raised.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_issue         = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (i_redirect) begin
                    w_fetch_pc_next = i_redirect_pc;
                    w_state_next    = FS_REQ;
                    w_issue         = 1'b1;
                end else if (w_has_space) begin
                    w_state_next = FS_REQ;
                    w_issue      = 1'b1;
                end
            end
            FS_REQ: begin
                if (i_imem_ready && !i_redirect) begin
                    w_fetch_pc_next = r_imem_addr + 8'd1;
                    w_issue         = w_has_space;
                    w_state_next    = w_has_space ? FS_REQ : FS_IDLE;
                end else if (i_imem_ready) begin
                    w_fetch_pc_next = i_redirect_pc;
                    w_issue         = 1'b1;
                end else if (i_redirect) begin
                    w_fetch_pc_next = i_redirect_pc;
                    w_state_next    = FS_KILL;
                end
            end
            FS_KILL: begin
                if (i_redirect) begin
                    w_fetch_pc_next = i_redirect_pc;
                end
                if (i_imem_ready) begin
                    w_state_next = FS_REQ;
                    w_issue      = 1'b1;
                end
            end
            default: begin
                w_state_next = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= FS_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (w_issue) begin
                r_imem_addr <= w_fetch_pc_next;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (i_redirect),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head)
    );

    assign o_imem_req  = (r_state != FS_IDLE);
    assign o_imem_addr = r_imem_addr;
    assign o_if_valid  = w_head_valid;
    assign o_pc_out    = w_head_valid ? w_head.pc : 8'h00;
    assign o_instr_out = w_head_valid ? w_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_we;
    logic       redir;
    logic [7:0] redir_pc;
    logic       imem_req;
    logic       imem_ready;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       if_valid;
    logic [7:0] pc_out;
    logic [7:0] instr_out;

    int mem_lat;
    int mem_wait;
    bit force_rdy;

    int n_checks;
    int n_fail;

    // Model: queue of fetched {pc,instr}, one outstanding request record.
    logic [15:0] mq[$];
    logic [7:0]  m_pc;
    logic [7:0]  m_addr;
    bit          m_out;
    bit          m_kill;

    always #5 clk = ~clk;

    assign imem_ready = (imem_req && (mem_wait >= mem_lat)) || force_rdy;
    assign imem_rdata = imem_addr ^ 8'h5A;

    fetch_unit #(
        .RESET_PC   (8'h00),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ready  (imem_ready),
        .i_imem_rdata  (imem_rdata),
        .i_id_write_en (id_we),
        .i_redirect    (redir),
        .i_redirect_pc (redir_pc),
        .o_if_valid    (if_valid),
        .o_pc_out      (pc_out),
        .o_instr_out   (instr_out)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 8'h00;
        m_addr = 8'h00;
        m_out  = 1'b0;
        m_kill = 1'b0;
    endtask

    task automatic compare_model();
        logic [15:0] head;
        head = (mq.size() > 0) ? mq[0] : 16'h0000;
        check8("imem_req",  {7'd0, imem_req}, {7'd0, m_out});
        check8("imem_addr", imem_addr, m_addr);
        check8("if_valid",  {7'd0, if_valid}, {7'd0, mq.size() > 0});
        check8("pc_out",    pc_out, head[15:8]);
        check8("instr_out", instr_out, head[7:0]);
    endtask

    // Called at a negedge with inputs driven; returns at the next negedge.
    task automatic cycle();
        bit pop;
        bit done;
        bit push;
        int wn;
        #1;
        compare_model();
        if (rst) begin
            model_reset();
        end else begin
            pop  = (mq.size() > 0) && id_we && !redir;
            done = m_out && imem_ready;
            push = done && !m_kill && !redir;
            if (redir) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({m_addr, imem_rdata});
            end
            if (push) m_pc = m_addr + 8'd1;
            if (redir) m_pc = redir_pc;
            if (done) m_out = 1'b0;
            else if (m_out && redir) m_kill = 1'b1;
            if (!m_out && mq.size() < DEPTH) begin
                m_out  = 1'b1;
                m_kill = 1'b0;
                m_addr = m_pc;
            end
        end
        wn = (rst || !imem_req || imem_ready) ? 0 : mem_wait + 1;
        @(posedge clk);
        #1;
        mem_wait = wn;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        #1;
        check8("rst_req",   {7'd0, imem_req}, 8'd0);
        check8("rst_addr",  imem_addr, 8'h00);
        check8("rst_valid", {7'd0, if_valid}, 8'd0);
        check8("rst_pc",    pc_out, 8'h00);
        check8("rst_instr", instr_out, 8'h00);
    endtask

    task automatic check_head(input string name, input logic [7:0] pc);
        #1;
        check8({name, "_valid"}, {7'd0, if_valid}, 8'd1);
        check8({name, "_pc"}, pc_out, pc);
        check8({name, "_instr"}, instr_out, pc ^ 8'h5A);
    endtask

    initial begin
        bit found;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        id_we     = 1'b1;
        redir     = 1'b0;
        redir_pc  = 8'h00;
        mem_lat   = 0;
        mem_wait  = 0;
        force_rdy = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();

        // Reset with a stray ready, then zero-wait streaming
        force_rdy = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        force_rdy = 1'b0;
        #1;
        check8("first_req", {7'd0, imem_req}, 8'd1);
        check8("first_addr", imem_addr, 8'h00);
        cycle();
        check_head("s0", 8'h00);
        cycle();
        check_head("s1", 8'h01);
        cycle();
        check_head("s2", 8'h02);
        repeat (4) cycle();

        // Decode stall fills the FIFO and stops requests
        id_we = 1'b0;
        repeat (6) cycle();
        #1;
        check8("stall_req", {7'd0, imem_req}, 8'd0);
        check8("stall_valid", {7'd0, if_valid}, 8'd1);
        id_we = 1'b1;
        repeat (10) cycle();

        // Redirect while a slow request is outstanding
        mem_lat = 3;
        repeat (10) cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem_req && !imem_ready && mem_wait >= 1) found = 1'b1;
            else cycle();
        end
        check8("kill_setup", {7'd0, found}, 8'd1);
        redir    = 1'b1;
        redir_pc = 8'h40;
        cycle();
        redir = 1'b0;
        #1;
        check8("kill_req", {7'd0, imem_req}, 8'd1);
        check8("kill_valid", {7'd0, if_valid}, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (if_valid) found = 1'b1;
            else cycle();
        end
        check8("kill_timeout", {7'd0, found}, 8'd1);
        check_head("kill_head", 8'h40);

        // Redirect coincident with ready and pop, zero-wait
        mem_lat = 0;
        repeat (5) cycle();
        redir    = 1'b1;
        redir_pc = 8'h80;
        cycle();
        redir = 1'b0;
        #1;
        check8("rd_valid", {7'd0, if_valid}, 8'd0);
        check8("rd_req", {7'd0, imem_req}, 8'd1);
        check8("rd_addr", imem_addr, 8'h80);
        cycle();
        check_head("rd_head", 8'h80);
        repeat (3) cycle();

        // PC wrap
        redir    = 1'b1;
        redir_pc = 8'hFE;
        cycle();
        redir = 1'b0;
        cycle();
        check_head("w0", 8'hFE);
        cycle();
        check_head("w1", 8'hFF);
        cycle();
        check_head("w2", 8'h00);
        cycle();
        check_head("w3", 8'h01);

        // Reset with the FIFO full
        id_we = 1'b0;
        repeat (5) cycle();
        #1;
        check8("full_valid", {7'd0, if_valid}, 8'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs();
        id_we = 1'b1;
        cycle();
        cycle();
        check_head("refetch", 8'h00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            id_we     = ($urandom % 10) < 7;
            redir     = ($urandom % 20) == 0;
            redir_pc  = 8'($urandom);
            rst       = ($urandom % 100) == 0;
            force_rdy = rst;
            if (($urandom % 50) == 0) mem_lat = int'($urandom_range(0, 3));
            cycle();
        end
        rst       = 1'b0;
        redir     = 1'b0;
        force_rdy = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
